hub75_row_shifter: RTL and testbench



---
 rtl/hub75_row_shifter.sv | 157 +++++++++++++++
 tb/tb_hub75_row_shifter.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hub75_row_shifter.sv
// HUB75 row shifter: fetches one row of packed pixels from the frame buffer and
// serialises a single bit-plane into the panel RGB shift registers with a divided shift clock.
module hub75_row_shifter #(
  parameter int hpixel_p     = 64,
  parameter int vpixel_p     = 64,
  parameter int bpp_p        = 8,
  parameter int segments_p   = 2,
  parameter int clk_div_wd_p = 8,
  localparam int addr_width_p    = $clog2(hpixel_p * vpixel_p),
  localparam int pix_bit_width_p = $clog2(bpp_p),
  localparam int data_width_p    = segments_p * 3 * bpp_p
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [clk_div_wd_p-1:0]    i_clk_div,
  input  logic                       i_tx_start,
  input  logic [addr_width_p-1:0]    i_init_addr,
  input  logic [pix_bit_width_p-1:0] i_pix_bit,
  output logic                       o_tx_ready,
  output logic                       o_tx_done,
  output logic                       o_rd_en,
  output logic [addr_width_p-1:0]    o_rd_addr,
  input  logic [data_width_p-1:0]    i_rd_data,
  output logic                       o_hub_clk,
  output logic [3*segments_p-1:0]    o_hub_rgb
);

  localparam int col_width_p = $clog2(hpixel_p);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, LOW, HIGH, DONE} state_t;

  state_t                     state_q, state_d;
  logic [col_width_p-1:0]     col_q, col_d;
  logic [clk_div_wd_p-1:0]    div_q, div_d;
  logic [clk_div_wd_p-1:0]    clk_div_q, clk_div_d;
  logic [addr_width_p-1:0]    base_q, base_d;
  logic [pix_bit_width_p-1:0] pix_bit_q, pix_bit_d;
  logic                       tx_ready_q, tx_ready_d;
  logic                       tx_done_q, tx_done_d;
  logic                       rd_en_q, rd_en_d;
  logic [addr_width_p-1:0]    rd_addr_q, rd_addr_d;
  logic                       hub_clk_q, hub_clk_d;
  logic [3*segments_p-1:0]    hub_rgb_q, hub_rgb_d;
  logic [3*segments_p-1:0]    plane_bits;
  logic [bpp_p-1:0]           field;

  // Field f of the read word is channel f = s*3+k; pick the selected bit-plane from each.
  always_comb begin
    plane_bits = '0;
    field      = '0;
    for (int f = 0; f < 3 * segments_p; f++) begin
      field = i_rd_data[f*bpp_p +: bpp_p];
      if (int'(pix_bit_q) < bpp_p) plane_bits[f] = field[pix_bit_q];
    end
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    div_d     = div_q;
    clk_div_d = clk_div_q;
    base_d    = base_q;
    pix_bit_d = pix_bit_q;
    rd_addr_d = rd_addr_q;
    hub_rgb_d = hub_rgb_q;
    case (state_q)
      IDLE: begin
        if (i_tx_start) begin
          base_d    = i_init_addr;
          pix_bit_d = i_pix_bit;
          clk_div_d = i_clk_div;
          col_d     = '0;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        hub_rgb_d = plane_bits;
        // LOAD is the first low cycle, so the low divider resumes at 1.
        if (clk_div_q == '0) begin
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d   = clk_div_wd_p'(1);
          state_d = LOW;
        end
      end
      LOW: begin
        if (div_q == clk_div_q) begin
          div_d   = '0;
          state_d = HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      HIGH: begin
        if (div_q == clk_div_q) begin
          div_d = '0;
          if (col_q == col_width_p'(hpixel_p - 1)) begin
            state_d = DONE;
          end else begin
            col_d   = col_q + 1'b1;
            state_d = FETCH;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == FETCH) rd_addr_d = base_d + addr_width_p'(col_d);
    tx_ready_d = (state_d == IDLE);
    tx_done_d  = (state_d == DONE);
    rd_en_d    = (state_d == FETCH);
    hub_clk_d  = (state_d == HIGH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      col_q      <= '0;
      div_q      <= '0;
      clk_div_q  <= '0;
      base_q     <= '0;
      pix_bit_q  <= '0;
      tx_ready_q <= 1'b1;
      tx_done_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      hub_clk_q  <= 1'b0;
      hub_rgb_q  <= '0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      div_q      <= div_d;
      clk_div_q  <= clk_div_d;
      base_q     <= base_d;
      pix_bit_q  <= pix_bit_d;
      tx_ready_q <= tx_ready_d;
      tx_done_q  <= tx_done_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      hub_clk_q  <= hub_clk_d;
      hub_rgb_q  <= hub_rgb_d;
    end
  end

  assign o_tx_ready = tx_ready_q;
  assign o_tx_done  = tx_done_q;
  assign o_rd_en    = rd_en_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_hub_clk  = hub_clk_q;
  assign o_hub_rgb  = hub_rgb_q;

endmodule

// File: tb/tb_hub75_row_shifter.sv
// Bench for hub75_row_shifter: frame-buffer responder, pin monitor, table-driven
// bit-plane vectors, hand-written corner sequences and randomized rows against a row model.
module tb_hub75_row_shifter;
  localparam int hpix = 64;
  localparam int bpp  = 8;
  localparam int nch  = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_clk_div;
  logic        i_tx_start;
  logic [11:0] i_init_addr;
  logic [2:0]  i_pix_bit;
  logic        o_tx_ready, o_tx_done, o_rd_en, o_hub_clk;
  logic [11:0] o_rd_addr;
  logic [47:0] i_rd_data;
  logic [5:0]  o_hub_rgb;

  hub75_row_shifter dut (
    .clk(clk), .rst(rst), .i_clk_div(i_clk_div), .i_tx_start(i_tx_start),
    .i_init_addr(i_init_addr), .i_pix_bit(i_pix_bit), .o_tx_ready(o_tx_ready),
    .o_tx_done(o_tx_done), .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr),
    .i_rd_data(i_rd_data), .o_hub_clk(o_hub_clk), .o_hub_rgb(o_hub_rgb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Frame-buffer contents: 0 = word equals address, 1 = constant word, 2 = address hash.
  int          fb_mode = 0;
  logic [47:0] fb_const = '0;

  function automatic logic [47:0] fb_word(input logic [11:0] a);
    logic [23:0] h;
    h = 24'(a) * 24'd40503;
    case (fb_mode)
      0:       return {36'd0, a};
      1:       return fb_const;
      default: return {h, a ^ 12'hA5C, ~a};
    endcase
  endfunction

  // Read data is valid the cycle after the strobe; junk otherwise to expose timing slips.
  always @(posedge clk)
    i_rd_data <= o_rd_en ? fb_word(o_rd_addr) : {16'($urandom), $urandom};

  function automatic logic [5:0] exp_plane(input logic [47:0] w, input int pb);
    logic [5:0] r;
    r = '0;
    for (int f = 0; f < nch; f++)
      if (pb < bpp) r[f] = 1'((w >> (f * bpp + pb)) & 48'd1);
    return r;
  endfunction

  // Pin monitor, sampled mid-cycle.
  logic [11:0] obs_addr[$];
  logic [5:0]  obs_rgb[$];
  int   done_cnt = 0, shape_err = 0, hi_run = 0, lo_run = 0, exp_cd = 0;
  bit   seen_high = 0;
  logic prev_clk = 1'b0;
  logic [5:0] prev_rgb = '0;

  always @(negedge clk) begin
    if (o_tx_done) done_cnt++;
    if (o_rd_en) obs_addr.push_back(o_rd_addr);
    if (o_hub_clk && !prev_clk) begin
      obs_rgb.push_back(o_hub_rgb);
      if (seen_high && lo_run != exp_cd + 2) shape_err++;
      seen_high = 1;
      hi_run = 0;
    end
    if (!o_hub_clk && prev_clk) begin
      if (hi_run != exp_cd + 1) shape_err++;
      lo_run = 0;
    end
    if (o_hub_clk) hi_run++; else lo_run++;
    if (o_hub_clk && prev_clk && o_hub_rgb != prev_rgb) shape_err++;
    prev_clk = o_hub_clk;
    prev_rgb = o_hub_rgb;
  end

  task automatic start_row(input logic [11:0] base, input logic [2:0] pb, input logic [7:0] cd);
    obs_addr.delete();
    obs_rgb.delete();
    shape_err = 0;
    seen_high = 0;
    exp_cd = int'(cd);
    i_init_addr = base;
    i_pix_bit   = pb;
    i_clk_div   = cd;
    i_tx_start  = 1'b1;
    @(posedge clk); #1;
    i_tx_start  = 1'b0;
    chk("ready_fall", longint'(o_tx_ready), 0);
    // Scramble the inputs; the row must keep using the captured values.
    i_init_addr = 12'($urandom);
    i_pix_bit   = 3'($urandom);
    i_clk_div   = 8'($urandom);
  endtask

  task automatic run_row(input logic [11:0] base, input logic [2:0] pb, input logic [7:0] cd,
                         input bit poke);
    int lat, d0, budget, mid;
    chk("ready_idle", longint'(o_tx_ready), 1);
    d0 = done_cnt;
    budget = hpix * (2 * int'(cd) + 3) + 20;
    mid = 10 * (2 * int'(cd) + 3) + 2;
    lat = -1;
    start_row(base, pb, cd);
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      i_tx_start = 1'b0;
      if (o_tx_done) begin
        lat = n;
        break;
      end
      if (poke && n == mid) i_tx_start = 1'b1;
    end
    // Counted from the accepting edge; the acceptance cycle itself is the +1.
    chk("latency", longint'(lat), longint'(hpix * (2 * int'(cd) + 3)));
    if (poke) i_tx_start = 1'b1;
    @(posedge clk); #1;
    i_tx_start = 1'b0;
    chk("ready_rise", longint'(o_tx_ready), 1);
    if (poke) begin
      repeat (3) @(posedge clk);
      #1;
      chk("poke_ignored", longint'({o_tx_ready, o_rd_en}), 2);
    end
    chk("done_count", longint'(done_cnt - d0), 1);
    chk("read_count", longint'(obs_addr.size()), hpix);
    chk("rise_count", longint'(obs_rgb.size()), hpix);
    chk("clk_shape", longint'(shape_err), 0);
  endtask

  task automatic check_data(input logic [11:0] base, input logic [2:0] pb);
    int a_err, r_err;
    logic [11:0] ea;
    a_err = 0;
    r_err = 0;
    for (int i = 0; i < hpix; i++) begin
      ea = 12'((int'(base) + i) % 4096);
      if (i >= obs_addr.size() || obs_addr[i] != ea) a_err++;
      if (i >= obs_rgb.size() || obs_rgb[i] != exp_plane(fb_word(ea), int'(pb))) r_err++;
    end
    chk("rd_addr_seq_errs", longint'(a_err), 0);
    chk("rgb_seq_errs", longint'(r_err), 0);
    ea = 12'((int'(base) + hpix - 1) % 4096);
    chk("rgb_hold", longint'(o_hub_rgb), longint'(exp_plane(fb_word(ea), int'(pb))));
  endtask

  typedef struct {
    logic [47:0] word;
    logic [2:0]  pb;
    logic [7:0]  cd;
    logic [5:0]  exp_rgb;
  } vec_t;

  vec_t tab[11];

  initial begin
    int r_err, d0, found;
    logic [11:0] b;
    logic [2:0]  p;
    logic [7:0]  c;

    tab[0]  = '{48'h0000_0000_00A5, 3'd0, 8'd3, 6'b000001};
    tab[1]  = '{48'h0000_0000_00A5, 3'd1, 8'd3, 6'b000000};
    tab[2]  = '{48'h0000_0000_00A5, 3'd2, 8'd3, 6'b000001};
    tab[3]  = '{48'h0000_0000_00A5, 3'd3, 8'd3, 6'b000000};
    tab[4]  = '{48'h0000_0000_00A5, 3'd4, 8'd3, 6'b000000};
    tab[5]  = '{48'h0000_0000_00A5, 3'd5, 8'd3, 6'b000001};
    tab[6]  = '{48'h0000_0000_00A5, 3'd6, 8'd3, 6'b000000};
    tab[7]  = '{48'h0000_0000_00A5, 3'd7, 8'd3, 6'b000001};
    tab[8]  = '{48'hFF00_0000_0000, 3'd5, 8'd0, 6'b100000};
    tab[9]  = '{48'h00FF_00FF_00FF, 3'd2, 8'd0, 6'b010101};
    tab[10] = '{48'hFFFF_FFFF_FFFF, 3'd6, 8'd1, 6'b111111};

    rst = 1'b1;
    i_clk_div = '0;
    i_tx_start = 1'b0;
    i_init_addr = '0;
    i_pix_bit = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_ready", longint'(o_tx_ready), 1);
    chk("rst_tx_done", longint'(o_tx_done), 0);
    chk("rst_rd_en", longint'(o_rd_en), 0);
    chk("rst_rd_addr", longint'(o_rd_addr), 0);
    chk("rst_hub_clk", longint'(o_hub_clk), 0);
    chk("rst_hub_rgb", longint'(o_hub_rgb), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Address-valued frame buffer, fastest shift clock.
    fb_mode = 0;
    run_row(12'h080, 3'd0, 8'd0, 0);
    check_data(12'h080, 3'd0);
    chk("first_read", longint'(obs_addr[0]), 12'h080);
    chk("last_read", longint'(obs_addr[hpix-1]), 12'h0BF);

    // Table vectors: constant word, every column must carry the listed plane bits.
    fb_mode = 1;
    for (int i = 0; i < 11; i++) begin
      fb_const = tab[i].word;
      run_row(12'($urandom), tab[i].pb, tab[i].cd, 0);
      r_err = 0;
      foreach (obs_rgb[j]) if (obs_rgb[j] != tab[i].exp_rgb) r_err++;
      chk($sformatf("tab%0d_rgb_errs", i), longint'(r_err), 0);
      chk($sformatf("tab%0d_rgb_hold", i), longint'(o_hub_rgb), longint'(tab[i].exp_rgb));
    end

    // Starts mid-row and during DONE are dropped.
    fb_mode = 2;
    run_row(12'h200, 3'd3, 8'd1, 1);
    check_data(12'h200, 3'd3);

    // Asynchronous abort during the high phase of column 20.
    d0 = done_cnt;
    start_row(12'h300, 3'd1, 8'd2);
    found = 0;
    for (int n = 0; n < 2000; n++) begin
      if (obs_addr.size() == 21 && o_hub_clk) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("reach_col20_high", longint'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_outputs",
        longint'({o_tx_ready, o_tx_done, o_rd_en, o_rd_addr, o_hub_clk, o_hub_rgb}),
        longint'({1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 6'h00}));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", longint'(done_cnt - d0), 0);
    run_row(12'h7C5, 3'd6, 8'd0, 0);
    check_data(12'h7C5, 3'd6);

    // Address wrap at the top of the frame buffer.
    fb_mode = 0;
    run_row(12'd4064, 3'd2, 8'd0, 0);
    check_data(12'd4064, 3'd2);
    chk("wrap_last_top", longint'(obs_addr[31]), 4095);
    chk("wrap_to_zero", longint'(obs_addr[32]), 0);

    // Randomized rows against the model.
    fb_mode = 2;
    for (int i = 0; i < 6; i++) begin
      b = 12'($urandom);
      p = 3'($urandom_range(0, 7));
      c = 8'($urandom_range(0, 3));
      run_row(b, p, c, 0);
      check_data(b, p);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
